// File: rtl/ptm_mem_arbiter.sv
// rtl/ptm_mem_arbiter.sv - round-robin two-requester arbiter for the PTM 1024x10 data memory
// Optional feature macro: PTM_ARB_TIMEOUT_EN (preempts an owner after MAX_BURST granted cycles).
module ptm_mem_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       en0,
  input  logic       en1,
  input  logic       we0,
  input  logic       we1,
  input  logic [9:0] addr0,
  input  logic [9:0] addr1,
  input  logic [9:0] wdata0,
  input  logic [9:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [9:0] rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [9:0] mem_addr,
  output logic [9:0] mem_wdata,
  input  logic [9:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state;
  logic   last;     // 1: requester 1 was granted most recently
  logic   expire;   // current owner has used up its burst allowance

  // Reject burst lengths the 8-bit counter cannot represent
  if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_burst
    $error("ptm_mem_arbiter: MAX_BURST must be within 2..255");
  end

`ifdef PTM_ARB_TIMEOUT_EN
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  logic [7:0] burst_cnt;
  assign expire = (burst_cnt == BURST_LAST);
`else
  assign expire = 1'b0;
`endif

  // Grant FSM: round-robin tie break, direct handoff, optional burst preemption
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
`ifdef PTM_ARB_TIMEOUT_EN
      burst_cnt <= '0;
`endif
    end else begin
`ifdef PTM_ARB_TIMEOUT_EN
      // Count granted cycles, saturating so a late competitor still preempts
      if (state != IDLE && !expire) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
`endif
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last)) begin
            state <= OWN0;
            last  <= 1'b0;
`ifdef PTM_ARB_TIMEOUT_EN
            burst_cnt <= '0;
`endif
          end else if (req1) begin
            state <= OWN1;
            last  <= 1'b1;
`ifdef PTM_ARB_TIMEOUT_EN
            burst_cnt <= '0;
`endif
          end
        end
        OWN0: begin
          if (!req0 || (expire && req1)) begin
            if (req1) begin
              state <= OWN1;
              last  <= 1'b1;
`ifdef PTM_ARB_TIMEOUT_EN
              burst_cnt <= '0;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        OWN1: begin
          if (!req1 || (expire && req0)) begin
            if (req0) begin
              state <= OWN0;
              last  <= 1'b0;
`ifdef PTM_ARB_TIMEOUT_EN
              burst_cnt <= '0;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);
  assign busy = gnt0 | gnt1;

  // Steer the granted requester onto the memory port; idle bus drives zeros
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_en    = en0;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_en    = en1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Read-valid follows the issuing strobe by one cycle, even across a handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & en0 & ~we0;
      rvalid1 <= gnt1 & en1 & ~we1;
    end
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_ptm_mem_arbiter.sv
// tb/tb_ptm_mem_arbiter.sv - scoreboard bench for ptm_mem_arbiter with a behavioural arbitration model
`timescale 1ns/1ps
module tb_ptm_mem_arbiter;

  localparam int BURST = 4;
`ifdef PTM_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, en0 = 1'b0, en1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [9:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_en, mem_we;
  logic [9:0] rdata, mem_addr, mem_wdata;
  logic [9:0] mem_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  int         own = -1;      // -1 idle, else owning requester
  bit         last = 1'b1;   // most recently granted requester
  int         tenure = 0;    // granted cycles in the current ownership
  int         q0[$];
  int         q1[$];
  logic [9:0] ref_mem [1024];
  logic [9:0] env_mem [1024];

  ptm_mem_arbiter #(.MAX_BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .en0(en0), .en1(en1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Latency-1 memory attached to the arbiter's memory port
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else mem_rdata <= env_mem[mem_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every read-valid pops the oldest expected word for that requester
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rvalid0_unexpected: got rvalid0=1 expected no read pending at %0t", $time);
      end else chk("rdata0", int'(rdata), q0.pop_front());
    end
    if (rvalid1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rvalid1_unexpected: got rvalid1=1 expected no read pending at %0t", $time);
      end else chk("rdata1", int'(rdata), q1.pop_front());
    end
  end

  // One clock cycle: check grants and memory port, apply the strobe, advance the model
  task automatic tick();
    int nxt;
    bit r_own, r_oth;
    int exp_bus;
    @(negedge clk);
    chk("gnt0", int'(gnt0), int'(own == 0));
    chk("gnt1", int'(gnt1), int'(own == 1));
    chk("busy", int'(busy), int'(own >= 0));
    if (own == 0) exp_bus = int'({en0, we0, addr0, wdata0});
    else if (own == 1) exp_bus = int'({en1, we1, addr1, wdata1});
    else exp_bus = 0;
    chk("mem_bus", int'({mem_en, mem_we, mem_addr, mem_wdata}), exp_bus);
    if (own == 0 && en0) begin
      if (we0) ref_mem[addr0] = wdata0;
      else q0.push_back(int'(ref_mem[addr0]));
    end
    if (own == 1 && en1) begin
      if (we1) ref_mem[addr1] = wdata1;
      else q1.push_back(int'(ref_mem[addr1]));
    end
    if (own < 0) begin
      if (req0 && req1) nxt = last ? 0 : 1;
      else if (req0) nxt = 0;
      else if (req1) nxt = 1;
      else nxt = -1;
    end else begin
      r_own = (own == 0) ? req0 : req1;
      r_oth = (own == 0) ? req1 : req0;
      if (!r_own) nxt = r_oth ? 1 - own : -1;
      else if (TIMEOUT && tenure >= BURST && r_oth) nxt = 1 - own;
      else nxt = own;
    end
    if (nxt >= 0 && nxt != own) begin
      last = (nxt == 1);
      tenure = 1;
    end else if (nxt >= 0) tenure++;
    own = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", int'({gnt0, gnt1, busy, mem_en, rvalid0, rvalid1}), 0);
    own = -1; last = 1'b1; tenure = 0;
    q0.delete(); q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    bit ended;
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] v;
      v = 10'($urandom_range(0, 1023));
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[5] = 10'h2A5;     ref_mem[5] = 10'h2A5;
    env_mem[10'h3FF] = 10'h155; ref_mem[10'h3FF] = 10'h155;

    @(posedge clk); #1;
    do_reset();

    // Cycle 2 request, cycle 3 grant, read of 0x005
    tick();
    req0 = 1; tick();
    chk("first_gnt0", int'(gnt0), 1);
    en0 = 1; we0 = 0; addr0 = 10'h005; tick();
    en0 = 0;
    chk("first_read", int'({rvalid0, rvalid1, rdata}), int'({1'b1, 1'b0, 10'h2A5}));
    req0 = 0; tick(); tick();

    // Tie after reset, handoff, tie again from idle
    do_reset();
    req0 = 1; req1 = 1; tick();
    chk("tie_gnt0", int'({gnt0, gnt1}), 2);
    req0 = 0; tick();
    chk("handoff_gnt1", int'({gnt0, gnt1}), 1);
    req1 = 0; tick();
    chk("idle_busy", int'(busy), 0);
    req0 = 1; req1 = 1; tick();
    chk("retie_gnt0", int'({gnt0, gnt1}), 2);

    // Non-granted write is ignored, granted write lands
    en1 = 1; we1 = 1; addr1 = 10'h3FF; wdata1 = 10'h3FF; tick();
    chk("ignored_write", int'(env_mem[10'h3FF]), 10'h155);
    en1 = 0; req0 = 0; tick();
    chk("gnt1_for_write", int'(gnt1), 1);
    en1 = 1; tick();
    chk("granted_write", int'(env_mem[10'h3FF]), 10'h3FF);
    we1 = 0; tick();
    en1 = 0;
    chk("readback_3ff", int'({rvalid1, rdata}), int'({1'b1, 10'h3FF}));

    // Read in the last granted cycle before a handoff
    req0 = 1; req1 = 0; tick();
    chk("gnt0_again", int'(gnt0), 1);
    req0 = 0; req1 = 1; en0 = 1; we0 = 0; addr0 = 10'h005; tick();
    en0 = 0;
    chk("inflight_read", int'({gnt1, rvalid0, rdata}), int'({1'b1, 1'b1, 10'h2A5}));

    // Asynchronous reset in the middle of a read
    req1 = 0; req0 = 1; tick();
    en0 = 1; we0 = 0; addr0 = 10'h005; tick();
    chk("pre_reset_rvalid0", int'({gnt0, rvalid0}), 3);
    #2;
    do_reset();
    en0 = 0;
    req0 = 1; req1 = 1; tick();
    chk("post_reset_tie", int'({gnt0, gnt1}), 2);
    req0 = 0; req1 = 0; tick(); tick();

    // Burst length with a competing requester
    req0 = 1; tick();
    run = 0; ended = 0;
    for (int i = 0; i < 15; i++) begin
      req0 = (i < 9); req1 = 1;
      if (!ended) begin
        if (gnt0) run++;
        else ended = 1;
      end
      tick();
    end
    chk("burst_len", run, TIMEOUT ? BURST : 10);
    req0 = 0; req1 = 0; tick(); tick();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      en0 = 1'($urandom_range(0, 1));
      en1 = 1'($urandom_range(0, 1));
      we0 = ($urandom_range(0, 3) == 0);
      we1 = ($urandom_range(0, 3) == 0);
      addr0 = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
      addr1 = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
      wdata0 = 10'($urandom_range(0, 1023));
      wdata1 = 10'($urandom_range(0, 1023));
      tick();
    end

    req0 = 0; req1 = 0; en0 = 0; en1 = 0;
    tick(); tick(); tick();
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ptm_mem_arbiter.md
# ptm_mem_arbiter

Two-requester arbiter that shares the single 1024x10 data memory between the PTM pattern-matcher read port and a second client, such as the testbench loader or a future DMA. Each requester holds the bus for a burst while its `req` is high. Ownership is granted with round-robin fairness, and an optional timeout preempts a requester that holds the bus too long. The memory is read-latency-1, and read data is steered back with per-requester valid strobes.

## Interface
Parameters:
- `MAX_BURST`, default 16: maximum consecutive granted cycles before preemption (timeout build only); legal range 2..255.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1 each  bus request; held high for the whole burst.
- `en0`, `en1`  in  1 each  access strobe, valid only while the matching grant is high.
- `we0`, `we1`  in  1 each  1 = write, 0 = read.
- `addr0`, `addr1`  in  10 each  word address.
- `wdata0`, `wdata1`  in  10 each  write data.
- `gnt0`, `gnt1`  out  1 each  registered grant; mutually exclusive.
- `rvalid0`, `rvalid1`  out  1 each  read data valid for that requester.
- `rdata`  out  10  read data, wired straight from `mem_rdata`.
- `mem_en`, `mem_we`  out  1 each  memory strobe and write enable.
- `mem_addr`, `mem_wdata`  out  10 each  memory address and write data.
- `mem_rdata`  in  10  memory read data, valid 1 cycle after a read strobe.
- `busy`  out  1  high while either grant is high.

## Operation
- FSM states: IDLE, OWN0, OWN1. `gnt0` = (state==OWN0), `gnt1` = (state==OWN1), `busy` = `gnt0` | `gnt1`.
- `last` register records the most recently granted requester; its reset value is 1, so `req0` wins the first tie.
- IDLE transitions:
  - only `req0` high -> OWN0.
  - only `req1` high -> OWN1.
  - both high -> the requester that is not `last`.
  - neither high -> stay in IDLE.
- OWN0 transitions:
  - `req0` low and `req1` high -> OWN1 (direct handoff, no idle cycle).
  - `req0` low and `req1` low -> IDLE.
  - otherwise stay in OWN0.
- OWN1 is symmetric to OWN0.
- `last` updates on every entry into OWN0 or OWN1.
- Memory mux is combinational from the granted requester:
  - `mem_en` = `gntX` & `enX`; `mem_we`, `mem_addr`, `mem_wdata` take requester X's values.
  - With no grant, `mem_en` = 0, `mem_we` = 0, and `mem_addr` and `mem_wdata` are 0.
- Strobes from the non-granted requester are ignored and produce no memory access and no `rvalid`.
- `rvalidX` is a register set to `gntX` & `enX` & ~`weX` from the previous cycle. It still fires if the grant dropped in between, so data already in flight is always delivered.
- Addresses pass through unmodified; there is no wrap or increment in this block.

## Timing
- Reset (`rst_n` low, asynchronous): state = IDLE, `last` = 1, burst counter = 0, `rvalid0` = `rvalid1` = 0. As a result `gnt0` = `gnt1` = `busy` = 0 and `mem_en` = 0.
- Reset asserted mid-burst drops the grant immediately and squashes any pending `rvalid`.
- Grant latency: `req` high in cycle N -> `gnt` high in cycle N+1. The first usable strobe is in cycle N+1.
- Release: `req` low in cycle N -> `gnt` low in N+1. The other requester, if its `req` was high in N, has `gnt` high in N+1.
- Read: strobe in cycle N -> `rdata` valid with `rvalidX` = 1 in cycle N+1.
- Back-to-back reads sustain one word per cycle.
- A write completes at the rising edge that ends its strobe cycle.
- Requesters must not deassert `req` in the same cycle as a strobe they need serviced. A strobe in the cycle `gnt` is high is always serviced.

## Configuration
- Macro: `PTM_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit burst counter clears on entry into OWNx and increments each cycle while in OWNx.
  - When the counter equals `MAX_BURST`-1 and the other `req` is high, the next state is the other OWN state.
  - The preempted requester loses its grant, is re-queued if its `req` stays high, and regains the bus by the normal rules.
  - If no other requester is waiting, the counter saturates and the owner keeps the bus.
- Not defined: no counter logic; the owner keeps the grant until it drops `req`.

## Test plan
- Reset, then `req0` = 1 at cycle 2 -> `gnt0` = 1 at cycle 3. Read of addr 0x005 (memory holds 0x2A5) at cycle 3 -> `rvalid0` = 1 and `rdata` = 0x2A5 at cycle 4; `rvalid1` stays 0.
- `req0` and `req1` rise together after reset -> `gnt0` first. `req0` drops -> `gnt1` next cycle with no idle gap. Both re-request from IDLE -> `gnt0` (`last` = 1).
- Requester 1 writes 0x3FF at addr 0x3FF while `gnt0` is high -> no memory write occurs and addr 0x3FF keeps its old value. Repeat after `gnt1` goes high -> memory holds 0x3FF.
- Read strobe in the last granted cycle before handoff -> `rvalid0` = 1 the next cycle while `gnt1` is already high, and `rdata` is correct.
- `rst_n` pulsed low mid-read -> `gnt0`, `rvalid0` and `mem_en` go to 0 immediately with no clock edge. After release, IDLE and `last` = 1.
- Timeout build with `MAX_BURST` = 4: `req0` held high and `req1` raised -> `gnt0` lasts exactly 4 cycles, then `gnt1`. Non-timeout build: `gnt0` holds until `req0` drops.
